// File: rtl/mem_pkg.sv
// Shared definitions for the streaming memory writer: FSM encoding, default sizes, address helper.
package mem_pkg;

    localparam int MW_DEPTH = 4;
    localparam int MW_CW    = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_CMP,
        S_FINISH
    } state_t;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] b, input logic [31:0] idx);
        return b + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock DEPTH x W FIFO; head word visible on dout with zero latency, pop takes effect at the edge.
// Backpressure: push ignored while full, pop ignored while empty; push+pop when neither keeps occupancy.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         push_ok, pop_ok;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mem_writer.sv
// Streams FIFO words to consecutive word addresses, optionally reads them back and compares checksums.
// Strobes are registered one cycle after each pop; in_ready drops only when the input FIFO is full.
module mem_writer
    import mem_pkg::*;
#(
    parameter int DEPTH = MW_DEPTH,
    parameter int CW    = MW_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [31:0]   base,
    input  logic [CW-1:0] count,
    input  logic          verify,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   address,
    output logic [31:0]   memIn,
    output logic          read,
    output logic          write,
    input  logic [31:0]   memOut,
    output logic          busy,
    output logic          done,
    output logic          error
);

    state_t        state_q, state_d;
    logic [31:0]   base_q, base_d;
    logic [CW-1:0] count_q, count_d;
    logic          verify_q, verify_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [31:0]   wsum_q, wsum_d;
    logic [31:0]   rsum_q, rsum_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdat_q, wdat_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          fifo_pop, fifo_full, fifo_empty;
    logic [31:0]   fifo_dout;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .din   (in_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign address  = addr_q;
    assign memIn    = wdat_q;
    assign read     = read_q;
    assign write    = write_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        count_d  = count_q;
        verify_d = verify_q;
        idx_d    = idx_q;
        wsum_d   = wsum_q;
        rsum_d   = rsum_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        error_d  = error_q;
        read_d   = 1'b0;
        write_d  = 1'b0;
        done_d   = 1'b0;
        fifo_pop = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = {base[31:2], 2'b00};
                    count_d  = count;
                    verify_d = verify;
                    idx_d    = '0;
                    wsum_d   = '0;
                    rsum_d   = '0;
                    error_d  = 1'b0;
                    if (count == '0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // idx reaching count means the last write strobe is on the bus this cycle.
                if (idx_q == count_q) begin
                    idx_d = '0;
                    if (verify_q) begin
                        state_d = S_RD_ADDR;
                        read_d  = 1'b1;
                        addr_d  = word_addr(base_q, 32'd0);
                    end else begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    write_d  = 1'b1;
                    wdat_d   = fifo_dout;
                    addr_d   = word_addr(base_q, 32'(idx_q));
                    wsum_d   = wsum_q + fifo_dout;
                    idx_d    = idx_q + CW'(1);
                end
            end
            S_RD_ADDR: begin
                state_d = S_RD_CMP;
            end
            S_RD_CMP: begin
                rsum_d = rsum_q + memOut;
                idx_d  = idx_q + CW'(1);
                if (idx_d == count_q) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                    error_d = (rsum_d != wsum_q);
                end else begin
                    state_d = S_RD_ADDR;
                    read_d  = 1'b1;
                    addr_d  = word_addr(base_q, 32'(idx_d));
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            count_q  <= '0;
            verify_q <= 1'b0;
            idx_q    <= '0;
            wsum_q   <= '0;
            rsum_q   <= '0;
            addr_q   <= '0;
            wdat_q   <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            count_q  <= count_d;
            verify_q <= verify_d;
            idx_q    <= idx_d;
            wsum_q   <= wsum_d;
            rsum_q   <= rsum_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            read_q   <= read_d;
            write_q  <= write_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

endmodule
